// File: rtl/acq_pkg.sv
// Shared state type and readout word layout for the acquisition sequencer.
// Defining ACQ_SEQUENCER_FRAMENUM_EN prepends a frame-number header word to every frame.
package acq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRun,
        StSnap,
        StReadout
    } acq_state_t;

`ifdef ACQ_SEQUENCER_FRAMENUM_EN
    localparam int unsigned WORD_HDR = 1;
`else
    localparam int unsigned WORD_HDR = 0;
`endif

    localparam int unsigned WORD_CLK   = WORD_HDR;
    localparam int unsigned WORD_CHAN0 = WORD_CLK + 1;

    function automatic int unsigned npairs(input int unsigned nchan);
        return nchan * (nchan - 1) / 2;
    endfunction

    function automatic int unsigned word_pair0(input int unsigned nchan);
        return WORD_CHAN0 + nchan;
    endfunction

    function automatic int unsigned nwords(input int unsigned nchan);
        return word_pair0(nchan) + npairs(nchan);
    endfunction

endpackage

// File: rtl/acq_readout_mux.sv
// Snapshot registers and word-by-word valid/ready readout of one acquisition frame.
// With ACQ_SEQUENCER_FRAMENUM_EN a frame counter is emitted as the first word.
module acq_readout_mux
    import acq_pkg::*;
#(
    parameter int unsigned NCHAN = 4,
    parameter int unsigned NBITS = 4,
    localparam int unsigned NPAIRS = npairs(NCHAN),
    localparam int unsigned NWORDS = nwords(NCHAN),
    localparam int unsigned IW = $clog2(NWORDS + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         capture,
    input  logic                         start,
    input  logic [NBITS-1:0]             cnt_clk,
    input  logic [NCHAN-1:0][NBITS-1:0]  cnt_chann,
    input  logic [NPAIRS-1:0][NBITS-1:0] cnt_pairs,
    input  logic                         ready,
    output logic                         valid,
    output logic [NBITS-1:0]             data,
    output logic [IW-1:0]                idx,
    output logic                         last,
    output logic                         frame_done
);

    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

    logic [NBITS-1:0]             snap_clk;
    logic [NCHAN-1:0][NBITS-1:0]  snap_chan;
    logic [NPAIRS-1:0][NBITS-1:0] snap_pair;
    logic                         valid_q;
    logic [IW-1:0]                idx_q;
    logic [NWORDS-1:0][NBITS-1:0] words;

    // Element 0 of the packed frame is the first word on the wire.
`ifdef ACQ_SEQUENCER_FRAMENUM_EN
    logic [NBITS-1:0] frame_q;
    assign words = {snap_pair, snap_chan, snap_clk, frame_q};
`else
    assign words = {snap_pair, snap_chan, snap_clk};
`endif

    assign valid      = valid_q;
    assign idx        = idx_q;
    assign data       = words[idx_q];
    assign last       = valid_q && (idx_q == LAST_IDX);
    assign frame_done = valid_q && ready && last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snap_clk  <= '0;
            snap_chan <= '0;
            snap_pair <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
`ifdef ACQ_SEQUENCER_FRAMENUM_EN
            frame_q   <= '0;
`endif
        end else begin
            if (capture) begin
                snap_clk  <= cnt_clk;
                snap_chan <= cnt_chann;
                snap_pair <= cnt_pairs;
            end
            if (start) begin
                valid_q <= 1'b1;
                idx_q   <= '0;
            end else if (valid_q && ready) begin
                if (last) begin
                    valid_q <= 1'b0;
                    idx_q   <= '0;
                end else begin
                    idx_q <= idx_q + IW'(1);
                end
            end
`ifdef ACQ_SEQUENCER_FRAMENUM_EN
            if (frame_done) begin
                frame_q <= frame_q + NBITS'(1);
            end
`endif
        end
    end

endmodule

// File: rtl/acq_sequencer.sv
// Run controller for the coincidence detector: clear, gated window, snapshot, streamed readout.
// ACQ_SEQUENCER_FRAMENUM_EN adds a frame-number header word (handled in acq_readout_mux).
module acq_sequencer
    import acq_pkg::*;
#(
    parameter int unsigned NCHAN = 4,
    parameter int unsigned NBITS = 4,
    localparam int unsigned NPAIRS = npairs(NCHAN),
    localparam int unsigned NWORDS = nwords(NCHAN),
    localparam int unsigned IW = $clog2(NWORDS + 1)
) (
    input  logic                         Clk,
    input  logic                         Rst_n,
    input  logic                         Start_i,
    input  logic                         Stop_i,
    input  logic                         Continuous_i,
    input  logic [NBITS-1:0]             nCycles_i,
    output logic                         Restart_o,
    output logic                         Enable_o,
    output logic [NBITS-1:0]             nCycles_o,
    input  logic [NBITS-1:0]             Cnt_Clk_i,
    input  logic [NCHAN-1:0][NBITS-1:0]  Cnt_chann_i,
    input  logic [NPAIRS-1:0][NBITS-1:0] Cnt_pairs_i,
    output logic                         Rd_valid_o,
    input  logic                         Rd_ready_i,
    output logic [NBITS-1:0]             Rd_data_o,
    output logic [IW-1:0]                Rd_idx_o,
    output logic                         Rd_last_o,
    output logic                         Busy_o,
    output logic                         Done_o
);

    acq_state_t       state_q, state_d;
    logic [NBITS-1:0] ncyc_q;
    logic             stopped_q;
    logic             restart_q, enable_q, busy_q, done_q;
    logic             capture, load_ncyc, frame_done;

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        load_ncyc = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (Start_i) begin
                    state_d   = StClear;
                    load_ncyc = 1'b1;
                end
            end
            StClear: state_d = StRun;
            StRun: begin
                if ((Cnt_Clk_i >= ncyc_q) || Stop_i) begin
                    state_d = StSnap;
                    capture = 1'b1;
                end
            end
            StSnap: state_d = StReadout;
            StReadout: begin
                if (frame_done) begin
                    // An aborted window never re-arms, even in continuous mode.
                    if (Continuous_i && !stopped_q) begin
                        state_d   = StClear;
                        load_ncyc = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control outputs are registered decodes of the next state.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q   <= StIdle;
            ncyc_q    <= '0;
            stopped_q <= 1'b0;
            restart_q <= 1'b0;
            enable_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_ncyc) begin
                ncyc_q <= nCycles_i;
            end
            if (capture) begin
                stopped_q <= Stop_i;
            end
            restart_q <= (state_d == StClear);
            enable_q  <= (state_d == StRun);
            busy_q    <= (state_d != StIdle);
            done_q    <= frame_done;
        end
    end

    acq_readout_mux #(
        .NCHAN(NCHAN),
        .NBITS(NBITS)
    ) u_readout (
        .clk       (Clk),
        .rst_n     (Rst_n),
        .capture   (capture),
        .start     (state_q == StSnap),
        .cnt_clk   (Cnt_Clk_i),
        .cnt_chann (Cnt_chann_i),
        .cnt_pairs (Cnt_pairs_i),
        .ready     (Rd_ready_i),
        .valid     (Rd_valid_o),
        .data      (Rd_data_o),
        .idx       (Rd_idx_o),
        .last      (Rd_last_o),
        .frame_done(frame_done)
    );

    assign Restart_o = restart_q;
    assign Enable_o  = enable_q;
    assign Busy_o    = busy_q;
    assign Done_o    = done_q;
    assign nCycles_o = ncyc_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Self-checking bench for acq_sequencer: random-hit detector model plus frame scoreboard.
// Build with ACQ_SEQUENCER_FRAMENUM_EN to also check the frame-number header.
module tb_acq_sequencer;

    localparam int unsigned NCHAN  = 4;
    localparam int unsigned NBITS  = 4;
    localparam int unsigned NPAIRS = 6;
`ifdef ACQ_SEQUENCER_FRAMENUM_EN
    localparam int unsigned HDR = 1;
`else
    localparam int unsigned HDR = 0;
`endif
    localparam int unsigned NW   = HDR + 1 + NCHAN + NPAIRS;
    localparam int unsigned WCLK = HDR;

    logic                         Clk = 1'b0;
    logic                         Rst_n = 1'b0;
    logic                         Start_i = 1'b0;
    logic                         Stop_i = 1'b0;
    logic                         Continuous_i = 1'b0;
    logic [NBITS-1:0]             nCycles_i = '0;
    logic                         Rd_ready_i = 1'b1;
    logic                         Restart_o, Enable_o, Rd_valid_o, Rd_last_o, Busy_o, Done_o;
    logic [NBITS-1:0]             nCycles_o, Rd_data_o;
    logic [3:0]                   Rd_idx_o;
    logic [NBITS-1:0]             det_clk = '0;
    logic [NCHAN-1:0][NBITS-1:0]  det_chan = '0;
    logic [NPAIRS-1:0][NBITS-1:0] det_pair = '0;

    acq_sequencer #(
        .NCHAN(NCHAN),
        .NBITS(NBITS)
    ) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .Start_i     (Start_i),
        .Stop_i      (Stop_i),
        .Continuous_i(Continuous_i),
        .nCycles_i   (nCycles_i),
        .Restart_o   (Restart_o),
        .Enable_o    (Enable_o),
        .nCycles_o   (nCycles_o),
        .Cnt_Clk_i   (det_clk),
        .Cnt_chann_i (det_chan),
        .Cnt_pairs_i (det_pair),
        .Rd_valid_o  (Rd_valid_o),
        .Rd_ready_i  (Rd_ready_i),
        .Rd_data_o   (Rd_data_o),
        .Rd_idx_o    (Rd_idx_o),
        .Rd_last_o   (Rd_last_o),
        .Busy_o      (Busy_o),
        .Done_o      (Done_o)
    );

    initial forever #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_mode = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    // Detector stand-in: random hits per channel, pair counts on coincidences (i<j order).
    logic [NCHAN-1:0] hit;
    int               p;
    always @(posedge Clk) begin
        hit = NCHAN'($urandom);
        if (Restart_o === 1'b1) begin
            det_clk  <= '0;
            det_chan <= '0;
            det_pair <= '0;
        end else if (Enable_o === 1'b1) begin
            det_clk <= det_clk + 1'b1;
            p = 0;
            for (int i = 0; i < NCHAN; i++) begin
                if (hit[i]) det_chan[i] <= det_chan[i] + 1'b1;
                for (int j = i + 1; j < NCHAN; j++) begin
                    if (hit[i] && hit[j]) det_pair[p] <= det_pair[p] + 1'b1;
                    p++;
                end
            end
        end
    end

    initial forever begin
        @(posedge Clk);
        #1;
        case (ready_mode)
            0:       Rd_ready_i = 1'b1;
            1:       Rd_ready_i = ~Rd_ready_i;
            default: Rd_ready_i = 1'($urandom);
        endcase
    end

    // Monitor and scoreboard: the expected frame is the detector state in the last enabled cycle.
    int                           restart_cnt, enable_cnt, done_cnt, stall_err, frames_done_m;
    int                           t_restart, t_valid, t_done, t0;
    bit                           prev_en, prev_rs, prev_valid, prev_ready;
    logic [NBITS-1:0]             prev_data;
    logic [3:0]                   prev_idx;
    logic [NBITS-1:0]             win_clk;
    logic [NCHAN-1:0][NBITS-1:0]  win_chan;
    logic [NPAIRS-1:0][NBITS-1:0] win_pair;
    logic [NBITS-1:0]             exp_q[$], got_w[$];
    logic [3:0]                   got_i[$];
    bit                           got_l[$];

    always @(negedge Clk) begin
        if (!Rst_n) begin
            prev_en = 0; prev_rs = 0; prev_valid = 0; prev_ready = 0;
            frames_done_m = 0;
        end else begin
            if (Restart_o && !prev_rs) t_restart = cyc;
            if (Restart_o) restart_cnt++;
            if (Enable_o) begin
                enable_cnt++;
                win_clk = det_clk; win_chan = det_chan; win_pair = det_pair;
            end
            if (prev_en && !Enable_o) begin
`ifdef ACQ_SEQUENCER_FRAMENUM_EN
                exp_q.push_back(NBITS'(frames_done_m));
`endif
                exp_q.push_back(win_clk);
                for (int c = 0; c < NCHAN; c++) exp_q.push_back(win_chan[c]);
                for (int q = 0; q < NPAIRS; q++) exp_q.push_back(win_pair[q]);
            end
            if (prev_valid && !prev_ready) begin
                if (Rd_valid_o !== 1'b1 || Rd_data_o !== prev_data || Rd_idx_o !== prev_idx)
                    stall_err++;
            end
            if (Rd_valid_o && !prev_valid) t_valid = cyc;
            if (Rd_valid_o && Rd_ready_i) begin
                got_w.push_back(Rd_data_o);
                got_i.push_back(Rd_idx_o);
                got_l.push_back(Rd_last_o);
            end
            if (Done_o) begin
                done_cnt++;
                frames_done_m++;
                t_done = cyc;
            end
            prev_en = Enable_o; prev_rs = Restart_o;
            prev_valid = Rd_valid_o; prev_ready = Rd_ready_i;
            prev_data = Rd_data_o; prev_idx = Rd_idx_o;
        end
    end

    task automatic clear_stats();
        restart_cnt = 0; enable_cnt = 0; done_cnt = 0; stall_err = 0;
    endtask

    task automatic start_frame(input int n);
        @(posedge Clk); #1;
        nCycles_i = NBITS'(n);
        Start_i   = 1'b1;
        t0        = cyc;
        @(posedge Clk); #1;
        Start_i   = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int d0 = done_cnt;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge Clk);
            if (done_cnt != d0) begin
                ok = 1;
                break;
            end
        end
        #1;
    endtask

    // Pops one frame off both queues; returns mismatching words and a few fields of interest.
    task automatic pop_frame(output int bad, output int nonzero, output logic [NBITS-1:0] clk_w,
                             output logic [NBITS-1:0] hdr_w);
        logic [NBITS-1:0] w, e;
        logic [3:0]       ix;
        bit               l;
        bad = 0; nonzero = 0; clk_w = 'x; hdr_w = 'x;
        if (got_w.size() < NW || exp_q.size() < NW) begin
            bad = NW;
            got_w.delete(); got_i.delete(); got_l.delete(); exp_q.delete();
        end else begin
            for (int k = 0; k < NW; k++) begin
                w = got_w.pop_front(); ix = got_i.pop_front(); l = got_l.pop_front();
                e = exp_q.pop_front();
                if (w !== e || ix !== 4'(k) || l !== (k == NW - 1)) bad++;
                if (k >= WCLK && w !== '0) nonzero++;
                if (k == WCLK) clk_w = w;
                if (k == 0) hdr_w = w;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if ({Restart_o, Enable_o, Busy_o, Done_o, Rd_valid_o, Rd_last_o} !== 6'b0)
            begin errors++; $display("FAIL reset_ctrl got %b want 000000",
                {Restart_o, Enable_o, Busy_o, Done_o, Rd_valid_o, Rd_last_o}); end
        checks++;
        if ({nCycles_o, Rd_idx_o, Rd_data_o} !== 12'h0)
            begin errors++; $display("FAIL reset_data got %h want 000",
                {nCycles_o, Rd_idx_o, Rd_data_o}); end
        Rst_n = 1'b1;
        Stop_i = 1'b1;
        @(posedge Clk); #1;
        Stop_i = 1'b0;
        @(posedge Clk); #1;
        checks++;
        if (Busy_o !== 1'b0) begin errors++; $display("FAIL idle_stop got %b want 0", Busy_o); end
    endtask

    task automatic test_basic();
        bit ok; int bad, nz; logic [NBITS-1:0] cw, hw;
        ready_mode = 0; clear_stats();
        start_frame(5);
        wait_done(100, ok);
        pop_frame(bad, nz, cw, hw);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_done timeout got 0 want 1"); end
        checks++;
        if (restart_cnt != 1 || enable_cnt != 6)
            begin errors++; $display("FAIL basic_pulses got rs=%0d en=%0d want rs=1 en=6",
                restart_cnt, enable_cnt); end
        checks++;
        if (t_restart != t0 + 1 || t_valid != t0 + 9 || t_done != t0 + 9 + NW)
            begin errors++; $display("FAIL basic_latency got rs=%0d v=%0d d=%0d want %0d %0d %0d",
                t_restart - t0, t_valid - t0, t_done - t0, 1, 9, 9 + NW); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL basic_frame got %0d bad words want 0", bad); end
        checks++;
        if (cw !== 4'd5) begin errors++; $display("FAIL basic_word_clk got %0d want 5", cw); end
        checks++;
        if (Busy_o !== 1'b0 || Rd_valid_o !== 1'b0)
            begin errors++; $display("FAIL basic_idle got busy=%b valid=%b want 0 0",
                Busy_o, Rd_valid_o); end
    endtask

    task automatic test_zero();
        bit ok; int bad, nz; logic [NBITS-1:0] cw, hw;
        ready_mode = 0; clear_stats();
        start_frame(0);
        wait_done(100, ok);
        pop_frame(bad, nz, cw, hw);
        checks++;
        if (!ok || enable_cnt != 1)
            begin errors++; $display("FAIL zero_run got ok=%0d en=%0d want 1 1", ok, enable_cnt); end
        checks++;
        if (bad != 0 || nz != 0)
            begin errors++; $display("FAIL zero_words got bad=%0d nonzero=%0d want 0 0", bad, nz); end
        checks++;
        if (Busy_o !== 1'b0) begin errors++; $display("FAIL zero_idle got %b want 0", Busy_o); end
    endtask

    task automatic test_stop();
        bit ok; int bad, nz; logic [NBITS-1:0] cw, hw;
        ready_mode = 0; clear_stats();
        Continuous_i = 1'b1;
        start_frame(10);
        repeat (3) @(posedge Clk);
        #1;
        Stop_i = 1'b1;
        @(posedge Clk); #1;
        Stop_i = 1'b0;
        checks++;
        if (Enable_o !== 1'b0) begin errors++; $display("FAIL stop_enable got %b want 0", Enable_o); end
        wait_done(100, ok);
        pop_frame(bad, nz, cw, hw);
        checks++;
        if (!ok || enable_cnt != 3)
            begin errors++; $display("FAIL stop_run got ok=%0d en=%0d want 1 3", ok, enable_cnt); end
        checks++;
        if (bad != 0 || cw !== 4'd2)
            begin errors++; $display("FAIL stop_frame got bad=%0d clk=%0d want 0 2", bad, cw); end
        checks++;
        if (Busy_o !== 1'b0 || restart_cnt != 1)
            begin errors++; $display("FAIL stop_no_rearm got busy=%b rs=%0d want 0 1",
                Busy_o, restart_cnt); end
        Continuous_i = 1'b0;
    endtask

    task automatic test_stall();
        bit ok; int bad, nz, n; logic [NBITS-1:0] cw, hw;
        for (int it = 0; it < 4; it++) begin
            ready_mode = (it % 2 == 0) ? 1 : 2;
            clear_stats();
            n = $urandom_range(1, 15);
            start_frame(n);
            wait_done(300, ok);
            pop_frame(bad, nz, cw, hw);
            checks++;
            if (!ok || bad != 0 || cw !== 4'(n))
                begin errors++; $display("FAIL stall_frame it=%0d got ok=%0d bad=%0d clk=%0d want 1 0 %0d",
                    it, ok, bad, cw, n); end
            checks++;
            if (stall_err != 0 || done_cnt != 1)
                begin errors++; $display("FAIL stall_hold it=%0d got err=%0d done=%0d want 0 1",
                    it, stall_err, done_cnt); end
        end
        ready_mode = 0;
    endtask

    task automatic test_continuous();
        bit ok1, ok2; int bad1, bad2, nz; logic [NBITS-1:0] cw1, cw2, hw;
        ready_mode = 2; clear_stats();
        Continuous_i = 1'b1;
        start_frame(3);
        wait_done(200, ok1);
        checks++;
        if (t_restart != t_done)
            begin errors++; $display("FAIL cont_rearm got restart@%0d want done@%0d", t_restart, t_done); end
        Continuous_i = 1'b0;
        Start_i = 1'b1;
        @(posedge Clk); #1;
        Start_i = 1'b0;
        wait_done(200, ok2);
        pop_frame(bad1, nz, cw1, hw);
        pop_frame(bad2, nz, cw2, hw);
        checks++;
        if (!ok1 || !ok2 || bad1 != 0 || bad2 != 0)
            begin errors++; $display("FAIL cont_frames got ok=%0d%0d bad=%0d,%0d want 11 0,0",
                ok1, ok2, bad1, bad2); end
        checks++;
        if (cw1 !== 4'd3 || cw2 !== 4'd3)
            begin errors++; $display("FAIL cont_clk got %0d,%0d want 3,3", cw1, cw2); end
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if (restart_cnt != 2 || enable_cnt != 8 || Busy_o !== 1'b0)
            begin errors++; $display("FAIL cont_end got rs=%0d en=%0d busy=%b want 2 8 0",
                restart_cnt, enable_cnt, Busy_o); end
        ready_mode = 0;
    endtask

    task automatic test_reset_mid();
        bit found = 0, ok; int bad, nz, nf; logic [NBITS-1:0] cw, hw;
        ready_mode = 0; clear_stats();
        start_frame(4);
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge Clk);
            if (Rd_valid_o === 1'b1 && Rd_idx_o === 4'd4) found = 1;
        end
        Rst_n = 1'b0;
        @(posedge Clk); #1;
        checks++;
        if (!found || Rd_valid_o !== 1'b0 || Busy_o !== 1'b0 || Rd_idx_o !== 4'd0)
            begin errors++; $display("FAIL midreset got found=%0d valid=%b busy=%b idx=%0d want 1 0 0 0",
                found, Rd_valid_o, Busy_o, Rd_idx_o); end
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        got_w.delete(); got_i.delete(); got_l.delete(); exp_q.delete();
`ifdef ACQ_SEQUENCER_FRAMENUM_EN
        nf = 3;
`else
        nf = 2;
`endif
        for (int f = 0; f < nf; f++) begin
            start_frame($urandom_range(0, 6));
            wait_done(100, ok);
            pop_frame(bad, nz, cw, hw);
            checks++;
            if (!ok || bad != 0)
                begin errors++; $display("FAIL after_reset f=%0d got ok=%0d bad=%0d want 1 0",
                    f, ok, bad); end
`ifdef ACQ_SEQUENCER_FRAMENUM_EN
            checks++;
            if (hw !== 4'(f)) begin errors++; $display("FAIL frame_hdr got %0d want %0d", hw, f); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_stop();
        test_stall();
        test_continuous();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
